lbus_rx_arbiter: RTL
====================

# lbus_rx_arbiter

Packet-granular round-robin arbiter that merges the AXI4-Stream outputs of several LBUS receive converters (one per CMAC/LBUS port) onto a single AXI4-Stream master in the `sys_clk` domain. A grant is held from the first beat of a packet through its `tlast` beat, so packets are never interleaved. The port index of each packet is carried on `m_axis_tdest`. The output stage is a single register stage that presents AXI-compliant stable data under backpressure.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of input streams; must be 1 or greater, and need not be a power of 2.
- `M_TDATA_WIDTH`, default 8: data width in bytes, matching the width of the upstream converter output.
- `DEST_WIDTH`, default `max(1, $clog2(NUM_PORTS))`: width of `m_axis_tdest`.

Ports:
- `sys_clk`  in  1  block clock; everything is synchronous to its rising edge.
- `sys_resetn`  in  1  reset, asynchronous and active-low.
- `port_enable`  in  `NUM_PORTS`  per-port admission mask; 0 means the port is never granted a new packet.
- `s_axis_tvalid`  in  `NUM_PORTS`  per-port valid.
- `s_axis_tready`  out  `NUM_PORTS`  per-port ready.
- `s_axis_tdata`  in  `NUM_PORTS*M_TDATA_WIDTH*8`  data; port k occupies slice `[k*M_TDATA_WIDTH*8 +: M_TDATA_WIDTH*8]`.
- `s_axis_tkeep`  in  `NUM_PORTS*M_TDATA_WIDTH`  byte enables; port k occupies slice `[k*M_TDATA_WIDTH +: M_TDATA_WIDTH]`.
- `s_axis_tlast`  in  `NUM_PORTS`  per-port end of packet.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tdata`  out  `M_TDATA_WIDTH*8`  output data.
- `m_axis_tkeep`  out  `M_TDATA_WIDTH`  output byte enables.
- `m_axis_tlast`  out  1  output end of packet.
- `m_axis_tdest`  out  `DEST_WIDTH`  index of the source port.
- `busy`  out  1  high while a packet grant is held.

## Operation
- State machine with two states, IDLE and BUSY. The block also holds a grant register `gnt` (`DEST_WIDTH` bits) and a round-robin pointer `ptr`.
- IDLE:
  - The request vector is `req = s_axis_tvalid & port_enable`.
  - The winner is the first set bit of `req`, scanning from `ptr` upward and wrapping modulo `NUM_PORTS`.
  - If any request is set, register `gnt` = winner and go to BUSY.
  - If no request is set, stay in IDLE.
  - All `s_axis_tready` bits are 0 in IDLE.
- BUSY:
  - `s_axis_tready[gnt] = ~m_axis_tvalid | m_axis_tready`. All other ready bits are 0.
  - Beat accept means `s_axis_tvalid[gnt] & s_axis_tready[gnt]`. On accept, load the output register with that port's tdata, tkeep and tlast, plus `tdest = gnt`, and set `m_axis_tvalid = 1`.
  - When an accepted beat has `tlast = 1`: go to IDLE and set `ptr = (gnt+1) mod NUM_PORTS` (explicit compare-and-wrap, no power-of-2 masking).
  - When `s_axis_tvalid[gnt]` drops mid-packet: remain in BUSY on the same grant. There is no timeout and no preemption.
  - When `port_enable[gnt]` is deasserted mid-packet: the packet in flight completes. The mask only gates new grants.
- Output register:
  - `m_axis_tvalid` clears when `m_axis_tready = 1` and no new beat is loaded in the same cycle.
  - A simultaneous drain and load keeps `m_axis_tvalid = 1` with the new data.
  - While `m_axis_tvalid & ~m_axis_tready`, all `m_axis_*` outputs hold stable.
- `busy` = (state == BUSY).
- tkeep is passed through unmodified. Packets with all-zero tkeep are not filtered.
- With `NUM_PORTS = 1`, `m_axis_tdest` is constant 0 and the arbitration logic degenerates to a single request.

## Timing
- Reset (`sys_resetn = 0`, asynchronous) forces:
  - state = IDLE, `ptr` = 0, `gnt` = 0.
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tdest`, `busy` = 0.
  - `s_axis_tready` = all 0.
- Reset deassertion is used as received; the integrator synchronises the release to `sys_clk`.
- Reset mid-packet discards the registered beat and the grant. The downstream block sees a truncated packet; that is acceptable and does not need to be handled here.
- Latency from `s_axis_tvalid[k]` rising in IDLE to `m_axis_tvalid`:
  - cycle 0: arbitration.
  - cycle 1: `s_axis_tready[k] = 1`, beat accepted.
  - cycle 2: `m_axis_tvalid = 1`.
  - Total: 2 cycles.
- Throughput within a packet is 1 beat per cycle while `m_axis_tready = 1`.
- Exactly one idle arbitration cycle occurs on the input side between packets. The output therefore shows one bubble cycle per packet boundary at full rate.
- A simultaneous tlast accept and new requests: the new requests are arbitrated in the next IDLE cycle using the updated `ptr`.

## Test plan
- Port 0 only, 3-beat packet, `m_axis_tready = 1`:
  - `m_axis_tvalid` rises 2 cycles after `s_axis_tvalid[0]`.
  - Beats emerge in order with `tdest = 0`.
  - `tlast` is set on beat 3 only, and `busy` falls after the tlast accept.
- `NUM_PORTS = 3`, all ports continuously valid with 2-beat packets:
  - Packet order is 0, 1, 2, 0, 1.
  - There is never an interleave within a packet.
  - There is exactly one bubble between packets.
- Port 1 mid-packet with `s_axis_tvalid[1]` gapped for 4 cycles while port 0 is valid:
  - The grant stays on 1 and no port-0 beat appears until port 1 delivers tlast.
- `m_axis_tready` toggled 1-0-0-1 during a packet:
  - Output data, tkeep, tlast and tdest hold stable during stall cycles.
  - No beat is lost or duplicated; the scoreboard matches.
- `port_enable = 2'b01` with both ports valid, then port 0 deasserted mid-packet:
  - Port 1 is never granted.
  - The port-0 packet completes.
  - Afterwards, with `enable = 0`, no grant is issued and `busy = 0`.
- `sys_resetn` pulsed low in the middle of beat 2 of a packet:
  - All outputs are 0 immediately (asynchronously).
  - After release, the next grant starts from port 0.

Source files
------------

// File: rtl/lbus_rx_arbiter.sv
// Packet-granular round-robin merge of several LBUS receive streams onto one
// AXI4-Stream master; the source port index travels on m_axis_tdest.
module lbus_rx_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int M_TDATA_WIDTH = 8,
    parameter int DEST_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_resetn,
    input  logic [NUM_PORTS-1:0]                 port_enable,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    input  logic [NUM_PORTS*M_TDATA_WIDTH*8-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*M_TDATA_WIDTH-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [M_TDATA_WIDTH*8-1:0]           m_axis_tdata,
    output logic [M_TDATA_WIDTH-1:0]             m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic [DEST_WIDTH-1:0]                m_axis_tdest,
    output logic                                 busy
);

    localparam int DW = M_TDATA_WIDTH * 8;
    localparam int KW = M_TDATA_WIDTH;
    localparam logic [DEST_WIDTH-1:0] LAST_PORT = DEST_WIDTH'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEST_WIDTH-1:0] r_gnt;
    logic [DEST_WIDTH-1:0] w_gnt_nxt;
    logic [DEST_WIDTH-1:0] r_ptr;
    logic [DEST_WIDTH-1:0] w_ptr_nxt;
    logic [DEST_WIDTH:0]   w_pick;

    logic                  r_tvalid;
    logic [DW-1:0]         r_tdata;
    logic [KW-1:0]         r_tkeep;
    logic                  r_tlast;
    logic [DEST_WIDTH-1:0] r_tdest;

    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DW-1:0]         w_sel_data;
    logic [KW-1:0]         w_sel_keep;
    logic                  w_hit;
    logic                  w_out_free;
    logic                  w_accept;
    logic [NUM_PORTS-1:0]  w_tready;

    // Lowest set request at or above ptr, otherwise lowest set request overall.
    function automatic logic [DEST_WIDTH:0] rr_pick(
        input logic [NUM_PORTS-1:0]  req,
        input logic [DEST_WIDTH-1:0] ptr
    );
        logic [DEST_WIDTH-1:0] win_hi;
        logic [DEST_WIDTH-1:0] win_lo;
        logic                  found_hi;
        logic                  hit_hi;
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            hit_hi   = req[j] & (j >= int'(ptr));
            win_hi   = hit_hi ? DEST_WIDTH'(j) : win_hi;
            found_hi = found_hi | hit_hi;
            win_lo   = req[j] ? DEST_WIDTH'(j) : win_lo;
        end
        return {|req, (found_hi ? win_hi : win_lo)};
    endfunction

    assign w_out_free = ~r_tvalid | m_axis_tready;
    assign w_accept   = (r_state == ST_BUSY) & w_sel_valid & w_out_free;

    // Multiplex the granted port's stream and drive its ready.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_hit       = 1'b0;
        w_tready    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_hit       = (r_gnt == DEST_WIDTH'(i));
            w_sel_valid = w_hit ? s_axis_tvalid[i] : w_sel_valid;
            w_sel_last  = w_hit ? s_axis_tlast[i] : w_sel_last;
            w_sel_data  = w_hit ? s_axis_tdata[i*DW +: DW] : w_sel_data;
            w_sel_keep  = w_hit ? s_axis_tkeep[i*KW +: KW] : w_sel_keep;
            w_tready[i] = w_hit & (r_state == ST_BUSY) & w_out_free;
        end
    end

    assign s_axis_tready = w_tready;

    // Next state, grant capture and pointer advance after each tlast.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_pick      = rr_pick(s_axis_tvalid & port_enable, r_ptr);
        case (r_state)
            ST_IDLE: begin
                if (w_pick[DEST_WIDTH]) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = w_pick[DEST_WIDTH-1:0];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_accept && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (r_gnt == LAST_PORT) ? '0 : r_gnt + DEST_WIDTH'(1);
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Output register: loads on accept, holds while stalled, drains on ready.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tdest  <= '0;
        end else if (w_accept) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_sel_data;
            r_tkeep  <= w_sel_keep;
            r_tlast  <= w_sel_last;
            r_tdest  <= r_gnt;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end else begin
            r_tvalid <= r_tvalid;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdest  = r_tdest;
    assign busy          = (r_state == ST_BUSY);

endmodule
